// File: rtl/sync_acquire_sequencer.sv
// sync_acquire_sequencer
//   Hunts for a chain of SYNC_COUNT_IN consecutive sync words spaced exactly
//   BITCELLS_PER_WORD bit cells apart. An optional index-pulse timeout ends
//   the search early. It is enabled by defining SYNC_ACQ_INDEX_TIMEOUT_EN.
//   Without that macro, the index path is absent and TIMED_OUT is tied to 0.
//
// Ports
//   CLK_DATASEP     master clock (the only clock)
//   RESET_N         asynchronous active-low reset
//   CLKEN_DATASEP   data separator clock enable; qualifies SYNC_DET_IN sampling
//   BIT_STROBE      one pulse per bit cell
//   SYNC_DET_IN     sync-word-detected level; a 0->1 step is a sync event
//   INDEX_IN        raw asynchronous index pulse
//   START / ABORT   one-cycle search request / cancel (ABORT wins)
//   SYNC_COUNT_IN   consecutive sync words required (0 behaves as 1)
//   INDEX_LIMIT_IN  index edges allowed before timeout (0 = never)
//   BUSY            searching (HUNT or CHAIN)
//   FOUND           mark acquired, held until next START or reset
//   TIMED_OUT       search expired, held until next START or reset
//   SYNCS_SEEN      current chain length
//   STATE_OUT       IDLE=0 HUNT=1 CHAIN=2 DONE=3 TIMEOUT=4
module sync_acquire_sequencer #(
   parameter int BITCELLS_PER_WORD = 16,
   parameter int INDEX_LIMIT_W     = 8
) (
   input  logic                     CLK_DATASEP,
   input  logic                     RESET_N,
   input  logic                     CLKEN_DATASEP,
   input  logic                     BIT_STROBE,
   input  logic                     SYNC_DET_IN,
   input  logic                     INDEX_IN,
   input  logic                     START,
   input  logic                     ABORT,
   input  logic [2:0]               SYNC_COUNT_IN,
   input  logic [INDEX_LIMIT_W-1:0] INDEX_LIMIT_IN,
   output logic                     BUSY,
   output logic                     FOUND,
   output logic                     TIMED_OUT,
   output logic [2:0]               SYNCS_SEEN,
   output logic [2:0]               STATE_OUT
);

   localparam int CELL_W = $clog2(BITCELLS_PER_WORD + 2);
   localparam logic [CELL_W-1:0] CELL_WORD = CELL_W'(BITCELLS_PER_WORD);
   localparam logic [CELL_W-1:0] CELL_MAX  = CELL_W'(BITCELLS_PER_WORD + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HUNT    = 3'd1,
      ST_CHAIN   = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CELL_W-1:0] cell_cnt_q, cell_cnt_d, cell_inc;
   logic [2:0]        syncs_q, syncs_d, syncs_inc, eff_count;
   logic              found_q, found_d;
   logic              timed_out_q, timed_out_d;
   logic              sync_prev_q, sync_prev_d, sync_evt;
   logic              idx_expire;
   logic              searching;

   assign searching = (state_q == ST_HUNT) || (state_q == ST_CHAIN);

`ifdef SYNC_ACQ_INDEX_TIMEOUT_EN
   logic                     idx_meta_q, idx_meta_d;
   logic                     idx_sync_q, idx_sync_d;
   logic                     idx_prev_q, idx_prev_d;
   logic                     idx_edge;
   logic [INDEX_LIMIT_W-1:0] idx_cnt_q, idx_cnt_d, idx_cnt_inc;

   always_comb begin
      idx_meta_d  = INDEX_IN;
      idx_sync_d  = idx_meta_q;
      idx_prev_d  = idx_sync_q;
      idx_edge    = idx_sync_q & ~idx_prev_q;
      idx_cnt_inc = (idx_edge && searching) ? idx_cnt_q + 1'b1 : idx_cnt_q;
      // Expiry looks at the count including this cycle's edge so the state
      // changes on the same clock the limiting edge is seen.
      idx_expire  = searching && (INDEX_LIMIT_IN != '0) && (idx_cnt_inc >= INDEX_LIMIT_IN);
      idx_cnt_d   = idx_cnt_q;
      if (ABORT || START) begin
         idx_cnt_d = '0;
      end else if (searching) begin
         idx_cnt_d = idx_cnt_inc;
      end
   end

   always_ff @(posedge CLK_DATASEP or negedge RESET_N) begin
      if (!RESET_N) begin
         idx_meta_q <= 1'b0;
         idx_sync_q <= 1'b0;
         idx_prev_q <= 1'b0;
         idx_cnt_q  <= '0;
      end else begin
         idx_meta_q <= idx_meta_d;
         idx_sync_q <= idx_sync_d;
         idx_prev_q <= idx_prev_d;
         idx_cnt_q  <= idx_cnt_d;
      end
   end

   assign TIMED_OUT = timed_out_q;
`else
   logic unused_index;
   assign unused_index = ^{INDEX_IN, INDEX_LIMIT_IN, timed_out_q};
   assign idx_expire   = 1'b0;
   assign TIMED_OUT    = 1'b0;
`endif

   always_comb begin
      eff_count   = (SYNC_COUNT_IN == 3'd0) ? 3'd1 : SYNC_COUNT_IN;
      sync_evt    = CLKEN_DATASEP & SYNC_DET_IN & ~sync_prev_q;
      sync_prev_d = CLKEN_DATASEP ? SYNC_DET_IN : sync_prev_q;
      // A strobe in the same cycle as a sync event is counted before the
      // spacing comparison; the counter saturates one past a full word.
      cell_inc    = (BIT_STROBE && (cell_cnt_q != CELL_MAX)) ? cell_cnt_q + 1'b1 : cell_cnt_q;
      syncs_inc   = syncs_q + 3'd1;

      state_d     = state_q;
      cell_cnt_d  = cell_cnt_q;
      syncs_d     = syncs_q;
      found_d     = found_q;
      timed_out_d = timed_out_q;

      if (ABORT) begin
         state_d    = ST_IDLE;
         syncs_d    = 3'd0;
         cell_cnt_d = '0;
      end else if (START) begin
         state_d     = ST_HUNT;
         syncs_d     = 3'd0;
         cell_cnt_d  = '0;
         found_d     = 1'b0;
         timed_out_d = 1'b0;
      end else begin
         case (state_q)
            ST_HUNT: begin
               if (sync_evt) begin
                  syncs_d    = 3'd1;
                  cell_cnt_d = '0;
                  if (eff_count == 3'd1) begin
                     state_d = ST_DONE;
                     found_d = 1'b1;
                  end else begin
                     state_d = ST_CHAIN;
                  end
               end else if (idx_expire) begin
                  state_d     = ST_TIMEOUT;
                  timed_out_d = 1'b1;
               end
            end
            ST_CHAIN: begin
               // A completing sync event beats a simultaneous timeout.
               if (sync_evt && (cell_inc == CELL_WORD) && (syncs_inc >= eff_count)) begin
                  syncs_d    = syncs_inc;
                  cell_cnt_d = '0;
                  state_d    = ST_DONE;
                  found_d    = 1'b1;
               end else if (idx_expire) begin
                  state_d     = ST_TIMEOUT;
                  timed_out_d = 1'b1;
               end else if (sync_evt && (cell_inc == CELL_WORD)) begin
                  syncs_d    = syncs_inc;
                  cell_cnt_d = '0;
               end else if (sync_evt) begin
                  // Mis-spaced sync word: it becomes the first of a new chain.
                  syncs_d    = 3'd1;
                  cell_cnt_d = '0;
               end else if (cell_inc == CELL_MAX) begin
                  state_d    = ST_HUNT;
                  syncs_d    = 3'd0;
                  cell_cnt_d = '0;
               end else begin
                  cell_cnt_d = cell_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge CLK_DATASEP or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         cell_cnt_q  <= '0;
         syncs_q     <= 3'd0;
         found_q     <= 1'b0;
         timed_out_q <= 1'b0;
         sync_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cell_cnt_q  <= cell_cnt_d;
         syncs_q     <= syncs_d;
         found_q     <= found_d;
         timed_out_q <= timed_out_d;
         sync_prev_q <= sync_prev_d;
      end
   end

   assign BUSY       = searching;
   assign FOUND      = found_q;
   assign SYNCS_SEEN = syncs_q;
   assign STATE_OUT  = state_q;

endmodule

// File: tb/tb_sync_acquire_sequencer.sv
// Directed bench for sync_acquire_sequencer. Default parameters
// (BITCELLS_PER_WORD=16). The index timeout scenario follows the
// SYNC_ACQ_INDEX_TIMEOUT_EN macro of the build.
module tb_sync_acquire_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clken, strobe, sync_det, index_in, start, abort;
   logic [2:0] sync_count;
   logic [7:0] index_limit;
   logic       busy, found, timed_out;
   logic [2:0] syncs_seen, state_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sync_acquire_sequencer #(
      .BITCELLS_PER_WORD(16),
      .INDEX_LIMIT_W    (8)
   ) dut (
      .CLK_DATASEP   (clk),
      .RESET_N       (rst_n),
      .CLKEN_DATASEP (clken),
      .BIT_STROBE    (strobe),
      .SYNC_DET_IN   (sync_det),
      .INDEX_IN      (index_in),
      .START         (start),
      .ABORT         (abort),
      .SYNC_COUNT_IN (sync_count),
      .INDEX_LIMIT_IN(index_limit),
      .BUSY          (busy),
      .FOUND         (found),
      .TIMED_OUT     (timed_out),
      .SYNCS_SEEN    (syncs_seen),
      .STATE_OUT     (state_out)
   );

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Sync event lands on the first tick; the caller checks after it returns
   // only via sync_rise, then drops the level with sync_fall.
   task automatic sync_rise();
      sync_det = 1'b1;
      tick();
   endtask

   task automatic sync_fall();
      sync_det = 1'b0;
      tick();
   endtask

   task automatic strobes(input int n);
      strobe = 1'b1;
      repeat (n) tick();
      strobe = 1'b0;
   endtask

   task automatic index_pulse();
      index_in = 1'b1;
      repeat (3) tick();
      index_in = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_out); end
      total++; if ({busy, found, timed_out, syncs_seen} !== 6'b0) begin bad++; $display("FAIL reset_outputs got=%b want=000000", {busy, found, timed_out, syncs_seen}); end
      rst_n = 1'b1;
      repeat (2) tick();
      total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_idle_hold got=%0d want=0", state_out); end
   endtask

   task automatic test_chain_found();
      sync_count = 3'd3;
      do_start();
      total++; if (state_out !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL start_hunt got=%0d/%b want=1/1", state_out, busy); end
      sync_rise();
      total++; if (state_out !== 3'd2 || syncs_seen !== 3'd1) begin bad++; $display("FAIL found_ev1 got=%0d/%0d want=2/1", state_out, syncs_seen); end
      sync_fall();
      strobes(16);
      sync_rise();
      total++; if (state_out !== 3'd2 || syncs_seen !== 3'd2) begin bad++; $display("FAIL found_ev2 got=%0d/%0d want=2/2", state_out, syncs_seen); end
      sync_fall();
      strobes(16);
      sync_rise();
      total++; if (state_out !== 3'd3 || found !== 1'b1) begin bad++; $display("FAIL found_ev3 got=%0d/%b want=3/1", state_out, found); end
      total++; if (busy !== 1'b0 || syncs_seen !== 3'd3) begin bad++; $display("FAIL found_busy got=%b/%0d want=0/3", busy, syncs_seen); end
      sync_fall();
      total++; if (state_out !== 3'd3 || found !== 1'b1) begin bad++; $display("FAIL found_hold got=%0d/%b want=3/1", state_out, found); end
   endtask

   task automatic test_chain_restart();
      sync_count = 3'd3;
      do_start();
      total++; if (found !== 1'b0) begin bad++; $display("FAIL restart_clear_found got=%b want=0", found); end
      sync_rise(); sync_fall();
      strobes(16);
      sync_rise();
      total++; if (syncs_seen !== 3'd2) begin bad++; $display("FAIL restart_second got=%0d want=2", syncs_seen); end
      sync_fall();
      strobes(15);
      sync_rise();
      total++; if (syncs_seen !== 3'd1 || state_out !== 3'd2 || found !== 1'b0) begin bad++; $display("FAIL restart_short got=%0d/%0d/%b want=1/2/0", syncs_seen, state_out, found); end
      sync_fall();
   endtask

   task automatic test_chain_expire();
      sync_count = 3'd3;
      do_start();
      sync_rise(); sync_fall();
      strobes(16);
      total++; if (state_out !== 3'd2 || syncs_seen !== 3'd1) begin bad++; $display("FAIL expire_16 got=%0d/%0d want=2/1", state_out, syncs_seen); end
      strobes(1);
      total++; if (state_out !== 3'd1 || syncs_seen !== 3'd0) begin bad++; $display("FAIL expire_17 got=%0d/%0d want=1/0", state_out, syncs_seen); end
   endtask

   task automatic test_same_cycle();
      sync_count = 3'd2;
      do_start();
      sync_rise(); sync_fall();
      strobes(15);
      strobe   = 1'b1;
      sync_det = 1'b1;
      tick();
      strobe   = 1'b0;
      total++; if (state_out !== 3'd3 || found !== 1'b1 || syncs_seen !== 3'd2) begin bad++; $display("FAIL same_cycle got=%0d/%b/%0d want=3/1/2", state_out, found, syncs_seen); end
      sync_fall();
   endtask

   task automatic test_restart_while_busy();
      sync_count = 3'd3;
      do_start();
      total++; if (state_out !== 3'd1 || found !== 1'b0 || syncs_seen !== 3'd0) begin bad++; $display("FAIL restart_from_done got=%0d/%b/%0d want=1/0/0", state_out, found, syncs_seen); end
      sync_rise(); sync_fall();
      do_start();
      total++; if (state_out !== 3'd1 || syncs_seen !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL restart_from_chain got=%0d/%0d/%b want=1/0/1", state_out, syncs_seen, busy); end
   endtask

   task automatic test_single_count();
      sync_count = 3'd0;
      do_start();
      sync_rise();
      total++; if (state_out !== 3'd3 || found !== 1'b1 || syncs_seen !== 3'd1) begin bad++; $display("FAIL single_count got=%0d/%b/%0d want=3/1/1", state_out, found, syncs_seen); end
      sync_fall();
   endtask

   task automatic test_abort_start();
      sync_count = 3'd3;
      do_start();
      sync_rise(); sync_fall();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      total++; if (state_out !== 3'd0 || found !== 1'b0 || timed_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_start got=%0d/%b/%b/%b want=0/0/0/0", state_out, found, timed_out, busy); end
      sync_rise(); sync_fall();
      total++; if (state_out !== 3'd0) begin bad++; $display("FAIL abort_idle_hold got=%0d want=0", state_out); end
   endtask

`ifdef SYNC_ACQ_INDEX_TIMEOUT_EN
   task automatic test_index();
      sync_count  = 3'd3;
      index_limit = 8'd2;
      do_start();
      index_pulse();
      total++; if (state_out !== 3'd1 || timed_out !== 1'b0) begin bad++; $display("FAIL timeout_first got=%0d/%b want=1/0", state_out, timed_out); end
      index_pulse();
      total++; if (timed_out !== 1'b1 || busy !== 1'b0 || state_out !== 3'd4) begin bad++; $display("FAIL timeout_second got=%b/%b/%0d want=1/0/4", timed_out, busy, state_out); end
      do_start();
      total++; if (timed_out !== 1'b0 || state_out !== 3'd1) begin bad++; $display("FAIL timeout_clear got=%b/%0d want=0/1", timed_out, state_out); end
      index_limit = 8'd0;
   endtask
`else
   task automatic test_index();
      sync_count  = 3'd3;
      index_limit = 8'd2;
      do_start();
      index_pulse();
      index_pulse();
      total++; if (state_out !== 3'd1 || timed_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL index_ignored got=%0d/%b/%b want=1/0/1", state_out, timed_out, busy); end
      index_limit = 8'd0;
   endtask
`endif

   task automatic test_reset_mid_chain();
      sync_count = 3'd3;
      do_start();
      sync_rise(); sync_fall();
      strobes(16);
      sync_rise();
      total++; if (syncs_seen !== 3'd2 || state_out !== 3'd2) begin bad++; $display("FAIL mid_pre got=%0d/%0d want=2/2", syncs_seen, state_out); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({busy, found, timed_out, syncs_seen, state_out} !== 9'b0) begin bad++; $display("FAIL mid_async got=%b want=000000000", {busy, found, timed_out, syncs_seen, state_out}); end
      #2;
      rst_n    = 1'b1;
      sync_det = 1'b0;
      tick();
      sync_rise(); sync_fall();
      total++; if (state_out !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_stay_idle got=%0d/%b want=0/0", state_out, busy); end
   endtask

   initial begin
      rst_n       = 1'b0;
      clken       = 1'b1;
      strobe      = 1'b0;
      sync_det    = 1'b0;
      index_in    = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      sync_count  = 3'd3;
      index_limit = 8'd0;

      test_reset();
      test_chain_found();
      test_chain_restart();
      test_chain_expire();
      test_same_cycle();
      test_restart_while_busy();
      test_single_count();
      test_abort_start();
      test_index();
      test_reset_mid_chain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
